// File: rtl/apb_reg_completer.sv
// APB3 completer front-end driving a single-cycle strobe register port.
// Handles setup latching, wait states, address errors and ready timeout.
//
// Ports:
//   s_apb_*      APB3 completer side (pclk, async active-low presetn)
//   reg_addr_o   latched register address (paddr[REG_AW-1:0])
//   reg_*_en_o   one-cycle read/write strobes, the only qualifiers
//   reg_*_data   write data out / read data in (valid with reg_ready_i)
//   reg_ready_i  peripheral completion
module apb_reg_completer #(
  parameter int APB_AW     = 32,
  parameter int APB_DW     = 32,
  parameter int REG_AW     = 8,
  parameter int ADDR_RANGE = 'h100,
  parameter int TIMEOUT    = 16
) (
  input  logic              s_apb_pclk_i,
  input  logic              s_apb_presetn_i,
  input  logic              s_apb_psel_i,
  input  logic              s_apb_penable_i,
  input  logic              s_apb_pwrite_i,
  input  logic [APB_AW-1:0] s_apb_paddr_i,
  input  logic [APB_DW-1:0] s_apb_pwdata_i,
  output logic [APB_DW-1:0] s_apb_prdata_o,
  output logic              s_apb_pready_o,
  output logic              s_apb_pslverr_o,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic              reg_write_en_o,
  output logic [APB_DW-1:0] reg_write_data_o,
  output logic              reg_read_en_o,
  input  logic [APB_DW-1:0] reg_read_data_i,
  input  logic              reg_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [APB_DW-1:0] rdata_q, rdata_d;

  logic              setup;
  logic              bad_addr;

  logic [APB_DW-1:0] prdata_d;
  logic              pready_d;
  logic              pslverr_d;
  logic              wr_en_d;
  logic              rd_en_d;

  assign setup    = s_apb_psel_i & ~s_apb_penable_i;
  assign bad_addr = (s_apb_paddr_i >= APB_AW'(ADDR_RANGE))
                  | (s_apb_paddr_i[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          write_d = s_apb_pwrite_i;
          addr_d  = s_apb_paddr_i[REG_AW-1:0];
          wdata_d = s_apb_pwdata_i;
          rdata_d = '0;
          if (bad_addr) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = CW'(TIMEOUT - 1);
        if (!s_apb_psel_i) begin
          state_d = IDLE;
        end else if (reg_ready_i) begin
          rdata_d = reg_read_data_i;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!s_apb_psel_i) begin
          state_d = IDLE;
        end else if (reg_ready_i) begin
          rdata_d = reg_read_data_i;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are flops loaded from the next-state view, so each one is
  // valid in the same cycle the FSM occupies the matching state.
  always_comb begin
    pready_d  = (state_d == RESP);
    pslverr_d = pready_d & err_d;
    prdata_d  = '0;
    if (pready_d && !err_d && !write_d) begin
      prdata_d = rdata_d;
    end
    wr_en_d = (state_d == REQ) & write_d;
    rd_en_d = (state_d == REQ) & ~write_d;
  end

  always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
    if (!s_apb_presetn_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      s_apb_prdata_o  <= '0;
      s_apb_pready_o  <= 1'b0;
      s_apb_pslverr_o <= 1'b0;
      reg_write_en_o  <= 1'b0;
      reg_read_en_o   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      s_apb_prdata_o  <= prdata_d;
      s_apb_pready_o  <= pready_d;
      s_apb_pslverr_o <= pslverr_d;
      reg_write_en_o  <= wr_en_d;
      reg_read_en_o   <= rd_en_d;
    end
  end

  assign reg_addr_o       = addr_q;
  assign reg_write_data_o = wdata_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Self-checking bench for apb_reg_completer.
// Directed plus random APB transfers against a latency/response model.
module tb_apb_reg_completer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wdata;
  logic        reg_rd_en;
  logic [31:0] reg_rdata = '0;
  logic        reg_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  apb_reg_completer #(
    .APB_AW(32), .APB_DW(32), .REG_AW(8),
    .ADDR_RANGE('h100), .TIMEOUT(TO)
  ) dut (
    .s_apb_pclk_i     (clk),
    .s_apb_presetn_i  (rst_n),
    .s_apb_psel_i     (psel),
    .s_apb_penable_i  (penable),
    .s_apb_pwrite_i   (pwrite),
    .s_apb_paddr_i    (paddr),
    .s_apb_pwdata_i   (pwdata),
    .s_apb_prdata_o   (prdata),
    .s_apb_pready_o   (pready),
    .s_apb_pslverr_o  (pslverr),
    .reg_addr_o       (reg_addr),
    .reg_write_en_o   (reg_wr_en),
    .reg_write_data_o (reg_wdata),
    .reg_read_en_o    (reg_rd_en),
    .reg_read_data_i  (reg_rdata),
    .reg_ready_i      (reg_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/pready"}, 32'(pready), 32'd0);
    chk({tag, "/pslverr"}, 32'(pslverr), 32'd0);
    chk({tag, "/prdata"}, prdata, 32'd0);
    chk({tag, "/strobes"}, 32'({reg_wr_en, reg_rd_en}), 32'd0);
  endtask

  // d = cycles reg_ready stays low after the strobe cycle; ready is
  // pulsed once d cycles after the strobe (never if d > TO).
  task automatic xfer(input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int d,
                      input logic [31:0] rd, input string tag);
    bit          bad;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_stb;
    int          pr_cyc = -1;
    int          nstb = 0;
    logic        err_o = 1'b0;
    logic [31:0] rd_o = '0;
    bad = (addr >= 32'h100) || (addr[1:0] != 2'b00);
    if (bad) begin
      exp_cyc = 1; exp_err = 1'b1; exp_rd = '0; exp_stb = 0;
    end else if (d <= TO) begin
      exp_cyc = 2 + d; exp_err = 1'b0; exp_rd = wr ? 32'd0 : rd;
      exp_stb = 1;
    end else begin
      exp_cyc = TO + 2; exp_err = 1'b1; exp_rd = '0; exp_stb = 1;
    end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wd; reg_ready = 1'b0;
    for (int cyc = 1; cyc <= TO + 8; cyc++) begin
      @(posedge clk); #1;
      penable   = 1'b1;
      reg_ready = (cyc == 1 + d);
      reg_rdata = (cyc == 1 + d) ? rd : $urandom;
      @(negedge clk);
      if (reg_wr_en || reg_rd_en) begin
        nstb++;
        chk({tag, "/stb_cyc"}, 32'(cyc), 32'd1);
        chk({tag, "/stb_dir"}, 32'({reg_wr_en, reg_rd_en}),
            wr ? 32'd2 : 32'd1);
        chk({tag, "/reg_addr"}, 32'(reg_addr), 32'(addr[7:0]));
        if (wr) chk({tag, "/reg_wdata"}, reg_wdata, wd);
      end
      if (pready) begin
        pr_cyc = cyc;
        err_o  = pslverr;
        rd_o   = prdata;
        break;
      end
    end
    reg_ready = 1'b0;
    chk({tag, "/latency"}, 32'(pr_cyc), 32'(exp_cyc));
    chk({tag, "/pslverr"}, 32'(err_o), 32'(exp_err));
    chk({tag, "/prdata"}, rd_o, exp_rd);
    chk({tag, "/strobes"}, 32'(nstb), 32'(exp_stb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    int npr;
    int nst;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset/reg_addr", 32'(reg_addr), 32'd0);
    chk("reset/reg_wdata", reg_wdata, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed transfers
    xfer(1'b1, 32'h08, 32'hDEADBEEF, 0, 32'h0, "wr08");
    xfer(1'b0, 32'h04, 32'h0, 3, 32'h1234, "rd04");
    xfer(1'b0, 32'h100, 32'h0, 0, 32'h5555, "rd100");
    xfer(1'b0, 32'h06, 32'h0, 0, 32'h5555, "rd06");
    xfer(1'b1, 32'h3C, 32'hA5A5A5A5, 1000, 32'h0, "wr_timeout");
    xfer(1'b0, 32'hFC, 32'h0, TO, 32'hCAFEF00D, "rd_lastslot");
    xfer(1'b0, 32'h10, 32'h0, TO + 1, 32'hCAFEF00D, "rd_firstlate");
    idle(1);

    // Abort during WAIT with a late ready that must be ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    npr = 0; nst = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clk); #1;
      penable   = (cyc < 3);
      psel      = (cyc < 3);
      reg_ready = (cyc == 3);
      reg_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      if (pready) npr++;
      if (reg_rd_en || reg_wr_en) nst++;
    end
    reg_ready = 1'b0;
    chk("abort/pready", 32'(npr), 32'd0);
    chk("abort/strobes", 32'(nst), 32'd1);
    xfer(1'b0, 32'h0C, 32'h0, 2, 32'h0C0C0C0C, "rd0C_after_abort");

    // Reset pulsed while waiting on the peripheral
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h20; pwdata = 32'h11223344;
    repeat (2) begin
      @(posedge clk); #1;
      penable = 1'b1;
    end
    #2 rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    chk("midreset/reg_addr", 32'(reg_addr), 32'd0);
    chk("midreset/reg_wdata", reg_wdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("midreset_hold");
    rst_n = 1'b1;
    idle(1);
    xfer(1'b1, 32'h24, 32'h55AA55AA, 0, 32'h0, "wr_after_reset");

    // Random traffic, mix of back-to-back and gapped transfers
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          dl;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          a = 32'h100 + 32'($urandom_range(0, 'h3FF));
        else
          a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      end else begin
        a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      dl = ($urandom_range(0, 5) == 0) ? TO + 1 + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 6));
      xfer(1'($urandom), a, $urandom, dl, $urandom,
           $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    @(negedge clk);
    chk_quiet("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
